// File: rtl/proc16_pkg.sv
// Shared types and defaults for the 16-bit processor's fetch path.
package proc16_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bundle between the fetch unit, memory port 1, the branch unit and decode.
interface fetch_prefetch_unit_if import proc16_pkg::*; #(
    parameter int ADDR_W = proc16_pkg::ADDR_W,
    parameter int DATA_W = proc16_pkg::DATA_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;

    // Decode handshake: a word transfers on any rising edge where inst_valid
    // and inst_ready are both high; inst/inst_pc are stable while inst_valid
    // is high and unanswered, and inst_valid never depends on inst_ready.
    modport master (
        output mem_addr, mem_rd_en, inst_valid, inst, inst_pc,
        input  mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  mem_addr, mem_rd_en, inst_valid, inst, inst_pc,
        output mem_rdata, redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetched words; flush empties it in one cycle and wins over push/pop.
module fetch_fifo import proc16_pkg::*; #(
    parameter int DEPTH = 4
) (
    input  logic                       clcka,
    input  logic                       rst_n,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output fetch_entry_t               head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clcka or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch with prefetch FIFO and redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall/redirect counters.
module fetch_prefetch_unit #(
    parameter int                ADDR_W   = proc16_pkg::ADDR_W,
    parameter int                DATA_W   = proc16_pkg::DATA_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = proc16_pkg::RESET_PC
) (
    input  logic                      clcka,
    input  logic                      rst_n,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]               perf_stall_cnt,
    output logic [15:0]               perf_redirect_cnt,
`else
`endif
    fetch_prefetch_unit_if.master     bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_L = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0]        fetch_pc;
    logic [ADDR_W-1:0]        pc_tag;
    logic                     inflight;
    logic [CNT_W-1:0]         count;
    logic [CNT_W:0]           credit_used;
    logic                     issue;
    logic                     push;
    logic                     pop;
    proc16_pkg::fetch_entry_t push_entry;
    proc16_pkg::fetch_entry_t head_entry;

    // A slot is reserved for the in-flight word, so a response always fits.
    assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign issue       = rst_n && !bus.redirect_valid && (credit_used < DEPTH_L);
    assign push        = inflight && !bus.redirect_valid;
    assign pop         = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

    assign push_entry.inst = bus.mem_rdata;
    assign push_entry.pc   = pc_tag;

    always_ff @(posedge clcka or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            pc_tag   <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (bus.redirect_valid) begin
                fetch_pc <= bus.redirect_pc;
            end else if (issue) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
                pc_tag   <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clcka      (clcka),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .count      (count),
        .head       (head_entry)
    );

    assign bus.mem_addr   = fetch_pc;
    assign bus.mem_rd_en  = issue;
    assign bus.inst_valid = (count != '0);
    assign bus.inst       = head_entry.inst;
    assign bus.inst_pc    = head_entry.pc;

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clcka or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt    <= '0;
            perf_redirect_cnt <= '0;
        end else begin
            if (!bus.inst_valid && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
            if (bus.redirect_valid && (perf_redirect_cnt != 16'hFFFF)) begin
                perf_redirect_cnt <= perf_redirect_cnt + 16'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: queue-level fetch model plus directed literal checks.
module tb_fetch_prefetch_unit;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc;
    } ent_t;

    logic clcka = 1'b0;
    logic rst_n = 1'b0;
    always #5 clcka = ~clcka;

    fetch_prefetch_unit_if #(.ADDR_W(16), .DATA_W(16)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_stall_cnt;
    logic [15:0] perf_redirect_cnt;
`endif

    fetch_prefetch_unit #(
        .ADDR_W   (16),
        .DATA_W   (16),
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clcka             (clcka),
        .rst_n             (rst_n),
`ifdef FETCH_PERF_CNT_EN
        .perf_stall_cnt    (perf_stall_cnt),
        .perf_redirect_cnt (perf_redirect_cnt),
`endif
        .bus               (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory port 1: word at address a holds A000+a, returned one cycle after the read.
    initial bus.mem_rdata = '0;
    always @(posedge clcka) begin
        if (bus.mem_rd_en) bus.mem_rdata <= 16'hA000 + bus.mem_addr;
    end

    // Reference model: words fetched but not yet consumed, in order.
    ent_t        m_q[$];
    logic [15:0] m_pc;
    logic [15:0] m_tag;
    bit          m_inflight;
    int          m_stall;
    int          m_redir;
    int          cyc;
    int          first_valid_cyc;
    logic [15:0] dlv_pc_q[$];
    logic [15:0] dlv_inst_q[$];
    logic [15:0] iss_q[$];

    always @(negedge clcka) begin : compare
        bit   rv;
        bit   exp_valid;
        bit   exp_issue;
        bit   do_pop;
        bit   do_push;
        ent_t e;
        #1;
        if (!rst_n) begin
            m_q.delete();
            m_pc       = 16'h0000;
            m_tag      = 16'h0000;
            m_inflight = 1'b0;
            m_stall    = 0;
            m_redir    = 0;
            cyc        = 0;
            check("rst_rd_en",   bus.mem_rd_en,  0);
            check("rst_valid",   bus.inst_valid, 0);
            check("rst_inst",    bus.inst,       0);
            check("rst_inst_pc", bus.inst_pc,    0);
            check("rst_addr",    bus.mem_addr,   16'h0000);
`ifdef FETCH_PERF_CNT_EN
            check("rst_perf_stall", perf_stall_cnt,    0);
            check("rst_perf_redir", perf_redirect_cnt, 0);
`endif
        end else begin
            rv        = bus.redirect_valid;
            exp_valid = (m_q.size() != 0);
            exp_issue = !rv && ((m_q.size() + int'(m_inflight)) < DEPTH);
            check("mem_rd_en",  bus.mem_rd_en,  exp_issue);
            check("mem_addr",   bus.mem_addr,   m_pc);
            check("inst_valid", bus.inst_valid, exp_valid);
            if (exp_valid) begin
                check("inst",    bus.inst,    m_q[0].inst);
                check("inst_pc", bus.inst_pc, m_q[0].pc);
            end
`ifdef FETCH_PERF_CNT_EN
            check("perf_stall", perf_stall_cnt,    m_stall);
            check("perf_redir", perf_redirect_cnt, m_redir);
`endif
            if (bus.mem_rd_en) iss_q.push_back(bus.mem_addr);
            if (bus.inst_valid && (first_valid_cyc < 0)) first_valid_cyc = cyc;
            if (bus.inst_valid && bus.inst_ready && !rv) begin
                dlv_pc_q.push_back(bus.inst_pc);
                dlv_inst_q.push_back(bus.inst);
            end
            // Advance the model across the coming rising edge.
            do_pop  = exp_valid && bus.inst_ready && !rv;
            do_push = m_inflight && !rv;
            if (rv) begin
                m_q.delete();
            end else begin
                if (do_pop) void'(m_q.pop_front());
                if (do_push) begin
                    e.inst = 16'hA000 + m_tag;
                    e.pc   = m_tag;
                    m_q.push_back(e);
                end
            end
            if (rv) begin
                m_pc = bus.redirect_pc;
            end else if (exp_issue) begin
                m_tag = m_pc;
                m_pc  = m_pc + 16'd1;
            end
            m_inflight = exp_issue;
            if (!exp_valid && (m_stall < 65535)) m_stall++;
            if (rv && (m_redir < 65535)) m_redir++;
            cyc++;
        end
    end

    task automatic clear_logs();
        dlv_pc_q.delete();
        dlv_inst_q.delete();
        iss_q.delete();
        first_valid_cyc = -1;
    endtask

    task automatic drive(input bit rv, input logic [15:0] rpc, input bit rdy);
        @(negedge clcka);
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = rdy;
    endtask

    task automatic run(input int n, input bit rdy);
        repeat (n) drive(1'b0, 16'h0000, rdy);
    endtask

    task automatic do_reset(input bit rdy);
        @(negedge clcka);
        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        @(negedge clcka);
        @(negedge clcka);
        rst_n          = 1'b1;
        bus.inst_ready = rdy;
        clear_logs();
    endtask

    initial begin : watchdog
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int          n_0200;
        logic [15:0] exp_wrap[4];
        exp_wrap = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        first_valid_cyc    = -1;

        // Streaming from reset with decode always ready.
        do_reset(1'b1);
        run(8, 1'b1);
        check("first_valid_cycle", first_valid_cyc, 2);
        for (int i = 0; i < 4; i++) begin
            check("stream_pc",   dlv_pc_q[i],   i);
            check("stream_inst", dlv_inst_q[i], 16'hA000 + i);
        end

        // Decode stalled: exactly DEPTH issues, then fetch waits.
        do_reset(1'b0);
        run(8, 1'b0);
        #2;
        check("stall_issue_count", iss_q.size(), 4);
        check("stall_last_issue",  iss_q[3], 16'h0003);
        check("stall_full_valid",  bus.inst_valid, 1);
        check("stall_full_rd_en",  bus.mem_rd_en, 0);
        dlv_pc_q.delete();
        run(8, 1'b1);
        for (int i = 0; i < 5; i++) check("drain_pc", dlv_pc_q[i], i);

        // Single redirect mid-stream.
        run(5, 1'b1);
        drive(1'b1, 16'h0100, 1'b1);
        clear_logs();
        drive(1'b0, 16'h0000, 1'b1);
        #2;
        check("redir_valid_low", bus.inst_valid, 0);
        check("redir_addr",      bus.mem_addr, 16'h0100);
        check("redir_rd_en",     bus.mem_rd_en, 1);
        run(6, 1'b1);
        check("redir_first_pc",   dlv_pc_q[0],   16'h0100);
        check("redir_first_inst", dlv_inst_q[0], 16'hA100);

        // Back-to-back redirects: the second one wins.
        run(4, 1'b1);
        drive(1'b1, 16'h0200, 1'b1);
        clear_logs();
        drive(1'b1, 16'h0300, 1'b1);
        run(8, 1'b1);
        n_0200 = 0;
        foreach (dlv_pc_q[i]) if (dlv_pc_q[i][15:8] == 8'h02) n_0200++;
        check("b2b_no_0200",  n_0200, 0);
        check("b2b_first_pc", dlv_pc_q[0], 16'h0300);

        // PC wrap across FFFF.
        drive(1'b1, 16'hFFFE, 1'b1);
        clear_logs();
        run(8, 1'b1);
        for (int i = 0; i < 4; i++) check("wrap_pc", dlv_pc_q[i], exp_wrap[i]);

        // Asynchronous reset while the FIFO holds 3 entries.
        do_reset(1'b0);
        run(4, 1'b0);
        #2;
        check("pre_reset_valid", bus.inst_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.inst_valid, 0);
        check("async_rst_rd_en", bus.mem_rd_en, 0);
`ifdef FETCH_PERF_CNT_EN
        check("async_rst_stall_cnt", perf_stall_cnt, 0);
        check("async_rst_redir_cnt", perf_redirect_cnt, 0);
`endif
        @(negedge clcka);
        @(negedge clcka);
        rst_n          = 1'b1;
        bus.inst_ready = 1'b1;
        clear_logs();
        run(6, 1'b1);
        check("post_rst_issue", iss_q[0], 16'h0000);
        check("post_rst_pc",    dlv_pc_q[0], 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          rv;
            bit          rdy;
            logic [15:0] rpc;
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3)) : 16'($urandom);
            rdy = (i % 200 < 30) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            drive(rv, rpc, rdy);
        end
        run(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
